// File: rtl/simple_cpu_mc.sv
// Multi-cycle CPU: valid/ready instruction intake, parametrised register file and data memory.
// Optional condition flags (flag_z/flag_c) are built only when CPU_FLAGS_EN is defined.
module simple_cpu_mc #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int REG_SEL     = 2,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   busy,
  output logic                   done,
  input  logic [REG_SEL-1:0]     dbg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_data
`ifdef CPU_FLAGS_EN
  ,
  output logic                   flag_z,
  output logic                   flag_c
`endif
);

  localparam int NREG  = 2 ** REG_SEL;
  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   ready_q;
  logic                   done_q;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic [DATA_WIDTH-1:0]  s_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic [DATA_WIDTH-1:0]  regs_q [NREG];
  logic [DATA_WIDTH-1:0]  mem_q  [DEPTH];

  logic [1:0]            op_s;
  logic [REG_SEL-1:0]    x1_s;
  logic [REG_SEL-1:0]    x2_s;
  logic [REG_SEL-1:0]    x3_s;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [3:0]            funct_s;
  logic [ADDR_BITS-1:0]  addr_s;
  logic                  alu_wr_s;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  carry_d;

  assign op_s    = ir_q[INSTR_WIDTH-1 -: 2];
  assign x1_s    = ir_q[INSTR_WIDTH-3 -: REG_SEL];
  assign x2_s    = ir_q[INSTR_WIDTH-3-REG_SEL -: REG_SEL];
  assign x3_s    = ir_q[INSTR_WIDTH-3-2*REG_SEL -: REG_SEL];
  assign imm_s   = ir_q[DATA_WIDTH+3:4];
  assign funct_s = ir_q[3:0];
  assign addr_s  = result_q[ADDR_BITS-1:0];
  assign alu_wr_s = (op_s == OP_ALU) && (funct_s <= 4'd4);

  assign instr_ready = ready_q;
  assign busy        = ~ready_q;
  assign done        = done_q;
  assign dbg_data    = regs_q[dbg_sel];

  // EXEC-stage datapath: ALU result with carry/borrow, or effective address for memory ops
  always_comb begin
    logic [DATA_WIDTH:0] wide_s;
    wide_s   = '0;
    result_d = '0;
    carry_d  = 1'b0;
    case (op_s)
      OP_ALU: begin
        case (funct_s)
          4'd0: begin
            wide_s   = {1'b0, a_q} + {1'b0, b_q};
            result_d = wide_s[DATA_WIDTH-1:0];
            carry_d  = wide_s[DATA_WIDTH];
          end
          4'd1: begin
            wide_s   = {1'b0, a_q} - {1'b0, b_q};
            result_d = wide_s[DATA_WIDTH-1:0];
            carry_d  = wide_s[DATA_WIDTH];
          end
          4'd2:    result_d = a_q & b_q;
          4'd3:    result_d = a_q | b_q;
          4'd4:    result_d = a_q ^ b_q;
          default: result_d = '0;
        endcase
      end
      OP_LOAD, OP_STORE: result_d = a_q + imm_s;
      default:           result_d = '0;
    endcase
  end

`ifdef CPU_FLAGS_EN
  logic carry_q;
  logic flag_z_q;
  logic flag_c_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

  // Flags change only when an ALU op 0-4 retires; abort on reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        carry_q <= carry_d;
      end
      if ((state_q == S_WB) && alu_wr_s) begin
        flag_z_q <= (result_q == '0);
        flag_c_q <= carry_q;
      end
    end
  end
`else
  logic unused_carry_s;
  assign unused_carry_s = carry_d;
`endif

  // Control FSM with registered handshake/retire outputs, register file and data memory
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_WIDTH'(i);
      end
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (instr_valid) begin
            ir_q    <= instruction;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          a_q     <= regs_q[x2_s];
          b_q     <= regs_q[x3_s];
          s_q     <= regs_q[x1_s];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= result_d;
          if (op_s[1]) begin
            state_q <= S_MEM;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (op_s == OP_STORE) begin
            mem_q[addr_s] <= s_q;
          end else begin
            result_q <= mem_q[addr_s];
          end
          done_q  <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          if (alu_wr_s || (op_s == OP_LOAD)) begin
            regs_q[x1_s] <= result_q;
          end
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
